hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's load-use/mul-div hazard unit.
- Tracks every in-flight register write in a per-register scoreboard:
  - short timed entries for loads, with configurable latency;
  - long untimed entries for mul/div, held until the unit reports completion.
- Checks all ID source operands and the destination for RAW, WAW and structural hazards.
- Drives PC/IF-ID hold and ID/EX bubble control, gives branch-redirect flush priority, and counts stall cycles for performance monitoring.

Parameters:
- NUM_SRC, 2, number of source-register read ports checked in ID (1..3).
- REG_AW, 5, register address width; register count is 2**REG_AW; register 0 is hardwired zero.
- LOAD_LAT, 1, stall cycles a dependent instruction needs after a load issues (1..7).
- LAT_W, 3, width of the per-register load countdown; must hold LOAD_LAT.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs_valid  in  NUM_SRC  per-port: source operand actually read.
- id_rs  in  NUM_SRC*REG_AW  source addresses; port k = bits [k*REG_AW +: REG_AW].
- id_rd  in  REG_AW  destination address.
- id_we  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- id_is_muldiv  in  1  instruction is a multi-cycle mul/div.
- ex_flush  in  1  branch/jump redirect resolved in EX this cycle.
- md_done  in  1  mul/div result written back this cycle.
- md_done_rd  in  REG_AW  destination of the completing mul/div.
- stall  out  1  ID held this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register write enable.
- id_ex_flush  out  1  insert bubble into ID/EX.
- busy_vec  out  2**REG_AW  per-register pending-write flags.
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:

State:
- cnt[r] (LAT_W bits) and lbusy[r] (1 bit) for r = 1..2**REG_AW-1.
- md_busy: OR of all lbusy bits.
- stall_count register.
- Async reset clears all state: cnt = 0, lbusy = 0, stall_count = 0.
- With state cleared: stall = 0, pc_write = 1, if_id_write = 1, id_ex_flush = ex_flush, busy_vec = 0.

Hazard terms (combinational, evaluated only when id_valid = 1; all 0 otherwise):
- raw_t: any port k with id_rs_valid[k], id_rs[k] != 0 and cnt[id_rs[k]] != 0.
- raw_l: any port k with id_rs_valid[k], id_rs[k] != 0 and lbusy[id_rs[k]].
- waw: id_we, id_rd != 0 and lbusy[id_rd].
- struct: id_is_muldiv and md_busy.
- hazard = raw_t | raw_l | waw | struct.
- All checks use registered state only. md_done in the same cycle does not release a hazard; the release is seen the following cycle.

Outputs (combinational):
- stall = hazard & ~ex_flush.
- pc_write = ~stall.
- if_id_write = ~stall.
- id_ex_flush = stall | ex_flush.
- ex_flush has priority: the ID instruction is killed, so no stall is raised and nothing issues.
- busy_vec[r] = (cnt[r] != 0) | lbusy[r]; bit 0 is always 0.

Issue:
- issue = id_valid & ~stall & ~ex_flush.
- Only issuing instructions with id_we = 1 and id_rd != 0 update the scoreboard.

Per-cycle update, applied in this order at each clock edge:
1. Every nonzero cnt decrements by 1.
2. If md_done, clear lbusy[md_done_rd]. md_done_rd = 0 has no effect.
3. If issuing a load, cnt[id_rd] = LOAD_LAT; this overrides the decrement.
4. If issuing a mul/div, lbusy[id_rd] = 1. id_is_muldiv takes precedence if both class flags are set.
5. If issuing an ALU write, cnt[id_rd] = 0; EX/MEM forwarding covers it.

Load timing:
- With LOAD_LAT = 1, the instruction immediately after a load that reads its rd stalls exactly 1 cycle.
- With LOAD_LAT = N, it stalls N cycles.

Scoreboard entries are never cleared by ex_flush; only older, committed-path instructions hold entries.

stall_count increments on every cycle with stall = 1 and saturates at all-ones.

Reset asserted mid-operation clears everything immediately; pending mul/div results after reset are the mul/div unit's concern.

Test Plan:
- Reset, then load x5 followed by add x6,x5,x1 (LOAD_LAT=1) -> stall=1, pc_write=0, id_ex_flush=1 for exactly 1 cycle; add issues next cycle; stall_count=1.
- LOAD_LAT=3, load x7 then dependent reading x7 on port 1 -> 3 stall cycles; busy_vec[7]=1 for 3 cycles after the load issues.
- mul x8, then add reading x8; md_done with md_done_rd=8 asserted 10 cycles later -> stall for those 10 cycles plus the md_done cycle; issue on the next cycle; stall_count=11.
- mul x8 outstanding, ID holds div x9 -> structural stall until the cycle after md_done; ID holds addi x8 -> WAW stall; ID holds add x10,x0,x0 -> no stall.
- Load x5 followed by a dependent while ex_flush=1 -> stall=0, id_ex_flush=1, pc_write=1; the scoreboard entry for x5 still counts down.
- lbusy[12] set and stall active, then rst pulsed mid-cycle -> busy_vec=0, stall=0, stall_count=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard for the ID stage: timed load entries, untimed mul/div
// entries, RAW/WAW/structural hazard detection, pipeline hold control and a stall counter.
module hazard_scoreboard #(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC-1:0]        id_rs_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      id_is_muldiv,
    input  logic                      ex_flush,
    input  logic                      md_done,
    input  logic [REG_AW-1:0]         md_done_rd,
    output logic                      stall,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      id_ex_flush,
    output logic [2**REG_AW-1:0]      busy_vec,
    output logic [STALL_CNT_W-1:0]    stall_count
);

    localparam int unsigned NREG = 2**REG_AW;

    logic [NREG-1:0][LAT_W-1:0] cnt_q, cnt_d;
    logic [NREG-1:0]            lbusy_q, lbusy_d;
    logic [STALL_CNT_W-1:0]     stall_count_d;

    logic raw_t, raw_l, waw, struct_haz, hazard, md_busy, issue;

    // Entry 0 is never written, so md_busy and the lookups need no extra masking
    assign md_busy = |lbusy_q;

    always_comb begin
        raw_t      = 1'b0;
        raw_l      = 1'b0;
        waw        = 1'b0;
        struct_haz = 1'b0;
        if (id_valid) begin
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                if (id_rs_valid[k] && id_rs[k*REG_AW +: REG_AW] != '0) begin
                    if (cnt_q[id_rs[k*REG_AW +: REG_AW]] != '0) raw_t = 1'b1;
                    if (lbusy_q[id_rs[k*REG_AW +: REG_AW]])     raw_l = 1'b1;
                end
            end
            waw        = id_we && id_rd != '0 && lbusy_q[id_rd];
            struct_haz = id_is_muldiv && md_busy;
        end
    end

    assign hazard      = raw_t | raw_l | waw | struct_haz;
    assign stall       = hazard & ~ex_flush;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign id_ex_flush = stall | ex_flush;
    assign issue       = id_valid & ~stall & ~ex_flush;

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < int'(NREG); r++) begin
            busy_vec[r] = (cnt_q[r] != '0) | lbusy_q[r];
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        lbusy_d = lbusy_q;
        for (int r = 1; r < int'(NREG); r++) begin
            if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
        if (md_done && md_done_rd != '0) lbusy_d[md_done_rd] = 1'b0;
        // A new write to the same register supersedes the decrement and the md_done clear
        if (issue && id_we && id_rd != '0) begin
            if (id_is_muldiv)    lbusy_d[id_rd] = 1'b1;
            else if (id_is_load) cnt_d[id_rd]   = LAT_W'(LOAD_LAT);
            else                 cnt_d[id_rd]   = '0;
        end
    end

    always_comb begin
        stall_count_d = stall_count;
        if (stall && !(&stall_count)) stall_count_d = stall_count + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            lbusy_q     <= '0;
            stall_count <= '0;
        end else begin
            cnt_q       <= cnt_d;
            lbusy_q     <= lbusy_d;
            stall_count <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance a uses LOAD_LAT=1, instance b uses LOAD_LAT=3 and a 2-bit
// stall counter so saturation is exercised; both share the same stimulus.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_rs_valid;
    logic [9:0]  id_rs;
    logic [4:0]  id_rd;
    logic        id_we, id_is_load, id_is_muldiv, ex_flush, md_done;
    logic [4:0]  md_done_rd;

    logic        stall, pc_write, if_id_write, id_ex_flush;
    logic [31:0] busy_vec;
    logic [15:0] stall_count;
    logic        stall_b, pc_write_b, if_id_write_b, id_ex_flush_b;
    logic [31:0] busy_vec_b;
    logic [1:0]  stall_count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1), .LAT_W(3), .STALL_CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_valid(id_rs_valid), .id_rs(id_rs),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
        .ex_flush(ex_flush), .md_done(md_done), .md_done_rd(md_done_rd), .stall(stall),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush),
        .busy_vec(busy_vec), .stall_count(stall_count)
    );

    hazard_scoreboard #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(3), .LAT_W(3), .STALL_CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_valid(id_rs_valid), .id_rs(id_rs),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
        .ex_flush(ex_flush), .md_done(md_done), .md_done_rd(md_done_rd), .stall(stall_b),
        .pc_write(pc_write_b), .if_id_write(if_id_write_b), .id_ex_flush(id_ex_flush_b),
        .busy_vec(busy_vec_b), .stall_count(stall_count_b)
    );

    task automatic drive(input logic v, input logic [4:0] r1, input logic v1,
                         input logic [4:0] r2, input logic v2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic md);
        id_valid     = v;
        id_rs        = {r2, r1};
        id_rs_valid  = {v2, v1};
        id_rd        = rd;
        id_we        = we;
        id_is_load   = ld;
        id_is_muldiv = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ex_flush   = 1'b0;
        md_done    = 1'b0;
        md_done_rd = 5'd0;
    endtask

    // Inputs change 1 ns after the edge, outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin errors++;
            $display("FAIL reset_write_en: got %b%b want 11", pc_write, if_id_write); end
        checks++; if (id_ex_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", id_ex_flush); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
        ex_flush = 1'b1;
        #1;
        checks++; if (id_ex_flush !== 1'b1) begin errors++; $display("FAIL reset_flush_pass: got %b want 1", id_ex_flush); end
        ex_flush = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw x5
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_issue: got %b want 0", stall); end
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); // add x6,x5,x1
        #1;
        checks++; if ({stall, pc_write, if_id_write, id_ex_flush} !== 4'b1001) begin errors++;
            $display("FAIL load_use_stall: got %b want 1001", {stall, pc_write, if_id_write, id_ex_flush}); end
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL load_busy: got %b want 1", busy_vec[5]); end
        tick();
        #1;
        checks++; if ({stall, pc_write, id_ex_flush} !== 3'b010) begin errors++;
            $display("FAIL load_use_release: got %b want 010", {stall, pc_write, id_ex_flush}); end
        tick();
        idle();
        #1;
        checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_count); end
    endtask

    task automatic test_load_lat3();
        logic [3:0] exp_stall;
        exp_stall = 4'b0111; // bit i = expected stall in cycle i+1 after the load
        do_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); // lw x7
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0); // x7 on port 1
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (stall_b !== exp_stall[i]) begin errors++;
                $display("FAIL lat3_stall_c%0d: got %b want %b", i + 1, stall_b, exp_stall[i]); end
            checks++; if (busy_vec_b[7] !== exp_stall[i]) begin errors++;
                $display("FAIL lat3_busy_c%0d: got %b want %b", i + 1, busy_vec_b[7], exp_stall[i]); end
            tick();
        end
        idle();
        #1;
        checks++; if (stall_count_b !== 2'd3) begin errors++; $display("FAIL lat3_cnt: got %0d want 3", stall_count_b); end
    endtask

    task automatic test_muldiv_raw();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1); // mul x8
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); // add x9,x8,x1
        md_done_rd = 5'd8;
        for (int i = 1; i <= 11; i++) begin
            md_done = (i == 11);
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_raw_c%0d: got %b want 1", i, stall); end
            tick();
        end
        md_done = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || busy_vec[8] !== 1'b0) begin errors++;
            $display("FAIL md_raw_release: got stall=%b busy=%b want 0 0", stall, busy_vec[8]); end
        tick();
        idle();
        #1;
        checks++; if (stall_count !== 16'd11) begin errors++; $display("FAIL md_raw_cnt: got %0d want 11", stall_count); end
        checks++; if (stall_count_b !== 2'd3) begin errors++; $display("FAIL md_raw_sat: got %0d want 3", stall_count_b); end
    endtask

    task automatic test_struct_waw();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1); // mul x8
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1); // div x9
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL struct_stall: got %b want 1", stall); end
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0); // addi x8,x1
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", stall); end
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); // add x10,x0,x0
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall: got %b want 0", stall); end
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1); // div x9 again
        md_done    = 1'b1;
        md_done_rd = 5'd8;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL struct_done_cycle: got %b want 1", stall); end
        tick();
        md_done = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL struct_release: got %b want 0", stall); end
        tick();
        idle();
        #1;
        checks++; if (busy_vec[9] !== 1'b1 || busy_vec[8] !== 1'b0) begin errors++;
            $display("FAIL struct_busy: got x9=%b x8=%b want 1 0", busy_vec[9], busy_vec[8]); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        ex_flush = 1'b1;
        #1;
        checks++; if ({stall, id_ex_flush, pc_write} !== 3'b011) begin errors++;
            $display("FAIL flush_prio: got %b want 011", {stall, id_ex_flush, pc_write}); end
        checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b want 1", busy_vec[5]); end
        tick();
        idle();
        #1;
        checks++; if (busy_vec[5] !== 1'b0 || busy_vec_b[5] !== 1'b1) begin errors++;
            $display("FAIL flush_countdown: got a=%b b=%b want 0 1", busy_vec[5], busy_vec_b[5]); end
        checks++; if (busy_vec[6] !== 1'b0 || stall_count !== 16'd0) begin errors++;
            $display("FAIL flush_no_issue: got busy6=%b cnt=%0d want 0 0", busy_vec[6], stall_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1); // mul x12
        tick();
        drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        checks++; if (stall !== 1'b1 || busy_vec[12] !== 1'b1 || stall_count !== 16'd1) begin errors++;
            $display("FAIL pre_rst: got stall=%b busy=%b cnt=%0d want 1 1 1", stall, busy_vec[12], stall_count); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (busy_vec !== 32'h0 || stall !== 1'b0 || stall_count !== 16'd0) begin errors++;
            $display("FAIL async_rst: got busy=%h stall=%b cnt=%0d want 0 0 0", busy_vec, stall, stall_count); end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_load_lat3();
        test_muldiv_raw();
        test_struct_waw();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
